// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I widths, memory access sizes and result-select encodings
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;
endpackage

// File: rtl/ex_mem_stage_store_align.sv
// store_align: lane replication, byte enables and misalign flag (flag live only with EXMEM_MISALIGN_CHK_EN)
module store_align
  import riscv_pkg::*;
(
  input  logic [1:0]      size,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] data_rep,
  output logic [BE_W-1:0] byte_en,
  output logic            misalign
);
  always_comb begin
    data_rep = size == MEM_B ? {4{data[7:0]}} : size == MEM_H ? {2{data[15:0]}} : data;
    byte_en  = size == MEM_B ? 4'b0001 << addr :
               size == MEM_H ? 4'b0011 << addr :
               size == MEM_W ? 4'b1111 : 4'b0000;
`ifdef EXMEM_MISALIGN_CHK_EN
    misalign = (size == MEM_H && addr[0]) || (size == MEM_W && addr != 2'b00);
`else
    misalign = 1'b0;
`endif
  end
endmodule

// File: rtl/flop_en_rst_cl.sv
// flop_en_rst_cl: register with sync reset, sync clear and load enable (reset > clear > enable)
module flop_en_rst_cl #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= RESET_VAL;
    else if (clr) q <= CLEAR_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM register with stall/flush, valid gating and store alignment; EXMEM_MISALIGN_CHK_EN enables misalign check
module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int CTRL_EXT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallM,
  input  logic                  FlushM,
  input  logic                  IDEX_valid,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic [2:0]            Funct3E,
  input  logic [CTRL_EXT_W-1:0] CtrlExtE,
  input  logic [XLEN-1:0]       ALUResultE,
  input  logic [XLEN-1:0]       WriteDataE,
  input  logic [XLEN-1:0]       PCPlus4E,
  input  logic [4:0]            RdE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM,
  output logic [2:0]            Funct3M,
  output logic [CTRL_EXT_W-1:0] CtrlExtM,
  output logic [XLEN-1:0]       ALUResultM,
  output logic [XLEN-1:0]       PCPlus4M,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [XLEN/8-1:0]     ByteEnM,
  output logic [4:0]            RdM,
  output logic                  MisalignM,
  output logic                  EXMEM_valid
);
  localparam int W = 1 + 1 + 2 + 3 + CTRL_EXT_W + 3 * XLEN + XLEN / 8 + 5 + 1;
  if (XLEN != 32) begin : g_xlen_chk
    $error("ex_mem_stage: XLEN must be 32");
  end
  logic [XLEN-1:0]   data_rep;
  logic [XLEN/8-1:0] be_raw;
  logic              mis_raw;
  logic              rw_g, mw_g, mis_g;
  logic [1:0]        rs_g;
  logic [W-1:0]      d, q;
  store_align u_align (
    .size    (Funct3E[1:0]),
    .addr    (ALUResultE[1:0]),
    .data    (WriteDataE),
    .data_rep(data_rep),
    .byte_en (be_raw),
    .misalign(mis_raw)
  );
  // The illegal size 2'b11 and misaligned stores both suppress the write; RegWrite stays for the trap unit.
  always_comb begin
    rw_g  = RegWriteE & IDEX_valid;
    rs_g  = IDEX_valid ? ResultSrcE : 2'b00;
    mis_g = IDEX_valid & (MemWriteE | ResultSrcE == RESULT_SRC_MEM) & mis_raw;
    mw_g  = IDEX_valid & MemWriteE & Funct3E[1:0] != 2'b11 & ~mis_raw;
    d     = {rw_g, mw_g, rs_g, Funct3E, CtrlExtE, ALUResultE, PCPlus4E, data_rep,
             mw_g ? be_raw : '0, RdE, mis_g};
  end
  flop_en_rst_cl #(.WIDTH(W)) u_data_reg (
    .clk(clk), .rst(rst), .en(~StallM), .clr(FlushM), .d(d), .q(q)
  );
  flop_en_rst_cl #(.WIDTH(1)) u_valid_reg (
    .clk(clk), .rst(rst), .en(~StallM), .clr(FlushM), .d(IDEX_valid), .q(EXMEM_valid)
  );
  assign {RegWriteM, MemWriteM, ResultSrcM, Funct3M, CtrlExtM, ALUResultM, PCPlus4M, WriteDataM,
          ByteEnM, RdM, MisalignM} = q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed checks of reset, alignment, stall/flush, gating and back-to-back loads
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst, StallM, FlushM, IDEX_valid, RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  Funct3E;
  logic [3:0]  CtrlExtE;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [4:0]  RdE;
  logic        RegWriteM, MemWriteM, MisalignM, EXMEM_valid;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [3:0]  CtrlExtM, ByteEnM;
  logic [31:0] ALUResultM, PCPlus4M, WriteDataM;
  logic [4:0]  RdM;
  logic [117:0] all_out;
  int total = 0;
  int bad = 0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .StallM(StallM), .FlushM(FlushM), .IDEX_valid(IDEX_valid),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .Funct3E(Funct3E),
    .CtrlExtE(CtrlExtE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .CtrlExtM(CtrlExtM), .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ByteEnM(ByteEnM), .RdM(RdM), .MisalignM(MisalignM),
    .EXMEM_valid(EXMEM_valid)
  );

  always #5 clk = ~clk;
  assign all_out = {RegWriteM, MemWriteM, ResultSrcM, Funct3M, CtrlExtM, ALUResultM, PCPlus4M,
                    WriteDataM, ByteEnM, RdM, MisalignM, EXMEM_valid};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd);
    IDEX_valid = v; RegWriteE = rw; MemWriteE = mw; ResultSrcE = rs; Funct3E = f3;
    ALUResultE = addr; WriteDataE = wd; PCPlus4E = addr + 32'd4; RdE = rd; CtrlExtE = 4'hA;
  endtask

  initial begin
    rst = 1'b1; StallM = 1'b0; FlushM = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 2'b01, 3'b010, $urandom, $urandom, 5'd3);
    step();
    drive(1'b1, 1'b1, 1'b1, 2'b10, 3'b000, $urandom, $urandom, 5'd9);
    step();
    chk("reset_all_zero", all_out, '0);
    chk("reset_valid", EXMEM_valid, 1'b0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 2'b00, 3'b000, 32'h1003, 32'hAABBCCDD, 5'd0);
    step();
    chk("sb_wdata", WriteDataM, 32'hDDDDDDDD);
    chk("sb_be", ByteEnM, 4'b1000);
    chk("sb_mw", MemWriteM, 1'b1);
    chk("sb_valid", EXMEM_valid, 1'b1);
    chk("sb_addr", ALUResultM, 32'h1003);
    chk("sb_pc4", PCPlus4M, 32'h1007);
    chk("sb_ctrlext", CtrlExtM, 4'hA);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 32'h2000, 32'h12345678, 5'd0);
    step();
    chk("sw_be", ByteEnM, 4'b1111);
    chk("sw_wdata", WriteDataM, 32'h12345678);
    StallM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b000, 32'h3001 + i, 32'hFFFF0000, 5'd11);
      step();
      chk("stall_addr", ALUResultM, 32'h2000);
      chk("stall_wdata", WriteDataM, 32'h12345678);
      chk("stall_be", ByteEnM, 4'b1111);
      chk("stall_ctl", {RegWriteM, MemWriteM, ResultSrcM, EXMEM_valid}, 5'b01001);
    end
    FlushM = 1'b1;
    step();
    chk("stall_flush_zero", all_out, '0);
    StallM = 1'b0; FlushM = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 2'b01, 3'b010, 32'h40, 32'hCAFEF00D, 5'd4);
    step();
    chk("inv_ctl", {RegWriteM, MemWriteM, ResultSrcM, EXMEM_valid}, 5'b00000);
    chk("inv_be", ByteEnM, 4'b0000);
    chk("inv_addr", ALUResultM, 32'h40);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 3'b001, 32'h1001, 32'h0000BEEF, 5'd0);
    step();
`ifdef EXMEM_MISALIGN_CHK_EN
    chk("sh_mis_flag", MisalignM, 1'b1);
    chk("sh_mis_mw", MemWriteM, 1'b0);
    chk("sh_mis_be", ByteEnM, 4'b0000);
`else
    chk("sh_mis_flag", MisalignM, 1'b0);
    chk("sh_mis_mw", MemWriteM, 1'b1);
    chk("sh_mis_be", ByteEnM, 4'b0110);
`endif
    chk("sh_wdata", WriteDataM, 32'hBEEFBEEF);
    drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b011, 32'h10, 32'h55, 5'd6);
    IDEX_valid = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'b00;
    step();
    chk("f3_11_mw", MemWriteM, 1'b0);
    chk("f3_11_be", ByteEnM, 4'b0000);
    chk("f3_11_rw", RegWriteM, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 32'h0, 32'h11223344, 5'd0);
    step();
    chk("b2b_sw_be", ByteEnM, 4'b1111);
    chk("b2b_sw_valid", EXMEM_valid, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 32'h4, 32'h0, 5'd7);
    step();
    chk("b2b_lw_be", ByteEnM, 4'b0000);
    chk("b2b_lw_ctl", {RegWriteM, MemWriteM, ResultSrcM, Funct3M, RdM}, {1'b1, 1'b0, 2'b01, 3'b010, 5'd7});
    chk("b2b_lw_valid", EXMEM_valid, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 3'b100, 32'h5, 32'h000000EE, 5'd0);
    step();
    chk("b2b_sb_be", ByteEnM, 4'b0010);
    chk("b2b_sb_f3", Funct3M, 3'b100);
    chk("b2b_sb_valid", EXMEM_valid, 1'b1);
    StallM = 1'b1;
    step();
    chk("stall_hold_be", ByteEnM, 4'b0010);
    rst = 1'b1;
    step();
    chk("rst_mid_stall", all_out, '0);
    rst = 1'b0; StallM = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 2'b00, 3'b010, 32'h8, 32'h1, 5'd2);
    step();
    chk("reload_valid", EXMEM_valid, 1'b1);
    FlushM = 1'b1;
    step();
    chk("flush_zero", all_out, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
